f_minmax_stream: RTL and testbench

- Sequential stream consumer for IEEE-754 single-precision values, on the receiving side of the float comparison path.
- Accepts framed float words over a valid/ready handshake and compares each one against a running minimum and maximum.
- Emits one result per frame: min, max, element count and NaN flag, over a second valid/ready handshake.
- Sits downstream of float producers/ALUs in the floating-point datapath.

---
 rtl/f_pkg.sv | 22 ++
 rtl/f_lt_core.sv | 33 +++
 rtl/f_minmax_stream.sv | 163 ++++++++++++++++
 tb/tb_f_minmax_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/f_pkg.sv
// Shared IEEE-754 single-precision field constants, FSM state type and NaN test
// for the float min/max stream consumer.
package f_pkg;

    localparam int          SIGN_BIT = 31;
    localparam int          EXP_MSB  = 30;
    localparam int          EXP_LSB  = 23;
    localparam int          MANT_W   = 23;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_e;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MANT_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/f_lt_core.sv
// Combinational a < b for two non-NaN single-precision values.
// Signed zeros compare equal; infinities are ordinary extremes.
module f_lt_core
    import f_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    logic [30:0] a_mag;
    logic [30:0] b_mag;
    logic        a_neg;
    logic        b_neg;

    always_comb begin
        a_mag = a[EXP_MSB:0];
        b_mag = b[EXP_MSB:0];
        a_neg = a[SIGN_BIT];
        b_neg = b[SIGN_BIT];
        lt    = 1'b0;
        if ((a_mag == '0) && (b_mag == '0)) begin
            lt = 1'b0;
        end else if (a_neg != b_neg) begin
            lt = a_neg;
        end else if (a_neg) begin
            lt = (a_mag > b_mag);
        end else begin
            lt = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/f_minmax_stream.sv
// Per-frame running min/max/count/NaN over a float stream, one result per frame.
// Optional F_MINMAX_IDX_EN adds out_min_idx/out_max_idx (first-occurrence positions).
module f_minmax_stream
    import f_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_nan
`ifdef F_MINMAX_IDX_EN
    ,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx
`endif
);

    state_e           state_q, state_d;
    logic [31:0]      min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nan_q, nan_d, seen_q, seen_d;
    logic [31:0]      out_min_q, out_min_d, out_max_q, out_max_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_nan_q, out_nan_d;
`ifdef F_MINMAX_IDX_EN
    logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [CNT_W-1:0] out_min_idx_q, out_min_idx_d, out_max_idx_q, out_max_idx_d;
`endif

    logic             accept, first, word_nan, take_min, take_max;
    logic             base_seen, base_nan;
    logic [CNT_W-1:0] base_cnt;
    logic             new_lt_min, max_lt_new;

    f_lt_core u_lt_min (.a(in_data), .b(min_q),   .lt(new_lt_min));
    f_lt_core u_lt_max (.a(max_q),   .b(in_data), .lt(max_lt_new));

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_cnt   = out_cnt_q;
    assign out_nan   = out_nan_q;
`ifdef F_MINMAX_IDX_EN
    assign out_min_idx = out_min_idx_q;
    assign out_max_idx = out_max_idx_q;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        nan_d     = nan_q;
        seen_d    = seen_q;
        out_min_d = out_min_q;
        out_max_d = out_max_q;
        out_cnt_d = out_cnt_q;
        out_nan_d = out_nan_q;
`ifdef F_MINMAX_IDX_EN
        min_idx_d     = min_idx_q;
        max_idx_d     = max_idx_q;
        out_min_idx_d = out_min_idx_q;
        out_max_idx_d = out_max_idx_q;
`endif

        accept    = in_valid && in_ready;
        first     = (state_q == IDLE);
        word_nan  = is_nan(in_data);
        // A word accepted in IDLE opens a new frame, so stale accumulators are masked out.
        base_seen = !first && seen_q;
        base_nan  = !first && nan_q;
        base_cnt  = first ? '0 : cnt_q;
        take_min  = !word_nan && (!base_seen || new_lt_min);
        take_max  = !word_nan && (!base_seen || max_lt_new);

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    min_d  = take_min ? in_data : (first ? QNAN : min_q);
                    max_d  = take_max ? in_data : (first ? QNAN : max_q);
                    cnt_d  = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
                    nan_d  = base_nan || word_nan;
                    seen_d = base_seen || !word_nan;
`ifdef F_MINMAX_IDX_EN
                    min_idx_d = take_min ? base_cnt : (first ? '0 : min_idx_q);
                    max_idx_d = take_max ? base_cnt : (first ? '0 : max_idx_q);
`endif
                    if (in_last) begin
                        state_d   = HOLD;
                        out_min_d = min_d;
                        out_max_d = max_d;
                        out_cnt_d = cnt_d;
                        out_nan_d = nan_d;
`ifdef F_MINMAX_IDX_EN
                        out_min_idx_d = min_idx_d;
                        out_max_idx_d = max_idx_d;
`endif
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            nan_q     <= 1'b0;
            seen_q    <= 1'b0;
            out_min_q <= '0;
            out_max_q <= '0;
            out_cnt_q <= '0;
            out_nan_q <= 1'b0;
`ifdef F_MINMAX_IDX_EN
            min_idx_q     <= '0;
            max_idx_q     <= '0;
            out_min_idx_q <= '0;
            out_max_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            cnt_q     <= cnt_d;
            nan_q     <= nan_d;
            seen_q    <= seen_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
            out_cnt_q <= out_cnt_d;
            out_nan_q <= out_nan_d;
`ifdef F_MINMAX_IDX_EN
            min_idx_q     <= min_idx_d;
            max_idx_q     <= max_idx_d;
            out_min_idx_q <= out_min_idx_d;
            out_max_idx_q <= out_max_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_f_minmax_stream.sv
// Bench for f_minmax_stream: directed table of frames, reset/backpressure sequences,
// and random frames against a sort-key reference model. Small CNT_W exercises saturation.
module tb_f_minmax_stream;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_min;
    logic [31:0]      out_max;
    logic [CNT_W-1:0] out_cnt;
    logic             out_nan;
`ifdef F_MINMAX_IDX_EN
    logic [CNT_W-1:0] out_min_idx;
    logic [CNT_W-1:0] out_max_idx;
`endif

    always #5 clk = ~clk;

    f_minmax_stream #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_cnt   (out_cnt),
        .out_nan   (out_nan)
`ifdef F_MINMAX_IDX_EN
        ,
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx)
`endif
    );

    typedef struct {
        logic [31:0]      mn;
        logic [31:0]      mx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] mn_idx;
        logic [CNT_W-1:0] mx_idx;
        logic             nan;
    } exp_t;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [2:0]       n;
        logic [31:0]      mn;
        logic [31:0]      mx;
        logic [3:0]       cnt;
        logic             nan;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int n, input logic [31:0] mn, input logic [31:0] mx,
                                    input int cnt, input logic nan,
                                    input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.n = 3'(n); v.mn = mn; v.mx = mx; v.cnt = 4'(cnt); v.nan = nan;
        vecs.push_back(v);
    endfunction

    // Reference: map each non-NaN float onto a signed integer key (sign-magnitude to
    // two's complement, both zeros -> 0) and keep the first strict extreme.
    function automatic exp_t model(input logic [31:0] w[$]);
        exp_t   e;
        longint k, kmin, kmax;
        bit     seen;
        int     pos;
        seen = 0; kmin = 0; kmax = 0;
        e.mn = 32'h7FC00000; e.mx = 32'h7FC00000;
        e.mn_idx = '0; e.mx_idx = '0; e.nan = 1'b0;
        for (int i = 0; i < w.size(); i++) begin
            pos = (i > CMAX) ? CMAX : i;
            if (w[i][30:23] == 8'hFF && w[i][22:0] != 0) begin
                e.nan = 1'b1;
            end else begin
                k = w[i][31] ? -longint'(w[i][30:0]) : longint'(w[i][30:0]);
                if (!seen || k < kmin) begin kmin = k; e.mn = w[i]; e.mn_idx = CNT_W'(pos); end
                if (!seen || k > kmax) begin kmax = k; e.mx = w[i]; e.mx_idx = CNT_W'(pos); end
                seen = 1;
            end
        end
        e.cnt = CNT_W'((w.size() > CMAX) ? CMAX : w.size());
        return e;
    endfunction

    task automatic push(input logic [31:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    task automatic do_frame(input logic [31:0] w[$], input exp_t e, input string tag, input int stall);
        for (int i = 0; i < w.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            if (i == w.size() - 1) check({tag, ".valid_before_last"}, 32'(out_valid), 32'd0);
            push(w[i], (i == w.size() - 1));
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".min"},       out_min,        e.mn);
        check({tag, ".max"},       out_max,        e.mx);
        check({tag, ".cnt"},       32'(out_cnt),   32'(e.cnt));
        check({tag, ".nan"},       32'(out_nan),   32'(e.nan));
`ifdef F_MINMAX_IDX_EN
        check({tag, ".min_idx"},   32'(out_min_idx), 32'(e.mn_idx));
        check({tag, ".max_idx"},   32'(out_max_idx), 32'(e.mx_idx));
`endif
        out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_ready"}, 32'(in_ready),  32'd0);
            check({tag, ".stall_min"},   out_min,        e.mn);
            check({tag, ".stall_max"},   out_max,        e.mx);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".after_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".after_ready"}, 32'(in_ready),  32'd1);
        check({tag, ".after_min"},   out_min,        e.mn);
        check({tag, ".after_cnt"},   32'(out_cnt),   32'(e.cnt));
    endtask

    function automatic logic [31:0] gen_word(input logic [31:0] prev, input bit has_prev);
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return $urandom_range(0, 1) ? 32'h7F800000 : 32'hFF800000;
            3: return {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
            4: return has_prev ? prev : $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        exp_t        e;
        int          n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.min",       out_min,        32'd0);
        check("reset.max",       out_max,        32'd0);
        check("reset.cnt",       32'(out_cnt),   32'd0);
        check("reset.nan",       32'(out_nan),   32'd0);

        // Directed frames: n, min, max, cnt, nan, words.
        add_vec(3, 32'hC0000000, 32'h40600000, 3, 1'b0, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h0);
        add_vec(2, 32'h80000000, 32'h80000000, 2, 1'b0, 32'h80000000, 32'h00000000, 32'h0, 32'h0);
        add_vec(2, 32'h3F800000, 32'h3F800000, 2, 1'b1, 32'h7FC00000, 32'h3F800000, 32'h0, 32'h0);
        add_vec(1, 32'h7FC00000, 32'h7FC00000, 1, 1'b1, 32'h7F800001, 32'h0, 32'h0, 32'h0);
        add_vec(1, 32'hFF800000, 32'hFF800000, 1, 1'b0, 32'hFF800000, 32'h0, 32'h0, 32'h0);
        add_vec(2, 32'h00000000, 32'h7F800000, 2, 1'b0, 32'h7F800000, 32'h00000000, 32'h0, 32'h0);
        add_vec(4, 32'h00000000, 32'h40000000, 4, 1'b1, 32'h40000000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000);

        for (int i = 0; i < vecs.size(); i++) begin
            q = {};
            for (int j = 0; j < int'(vecs[i].n); j++) q.push_back(vecs[i].w[j]);
            e     = model(q);
            e.mn  = vecs[i].mn;
            e.mx  = vecs[i].mx;
            e.cnt = CNT_W'(vecs[i].cnt);
            e.nan = vecs[i].nan;
            do_frame(q, e, $sformatf("vec%0d", i), (i == 0) ? 5 : 0);
        end

        // Reset in the middle of a frame discards everything.
        push(32'h3F800000, 1'b0);
        push(32'hC1000000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.min",       out_min,        32'd0);
        check("midrst.max",       out_max,        32'd0);
        check("midrst.cnt",       32'(out_cnt),   32'd0);
        check("midrst.nan",       32'(out_nan),   32'd0);
        q = {};
        q.push_back(32'h40000000);
        e = model(q);
        do_frame(q, e, "post_rst", 0);

        // Random frames; the first one is long enough to saturate the counter.
        for (int f = 0; f < 40; f++) begin
            n = (f == 0) ? 20 : $urandom_range(1, 8);
            q = {};
            for (int j = 0; j < n; j++) q.push_back(gen_word((j > 0) ? q[j-1] : 32'h0, j > 0));
            e = model(q);
            do_frame(q, e, $sformatf("rnd%0d", f), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
